decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 161 ++++++++++++++++
 tb/tb_decode_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Zepto decode stage: splits an instruction into fields, decodes control, and
// registers the result behind a valid/ready handshake with a 2-entry skid buffer.
// Optional sticky illegal-opcode trap is enabled by defining DECODE_TRAP_EN.
module decode_stage #(
  parameter int INST_W   = 32,
  parameter int REG_W    = 4,
  parameter int XLEN     = 32,
  parameter int SEXT_IMM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_op,
  output logic [REG_W-1:0]  out_rd,
  output logic [REG_W-1:0]  out_ra,
  output logic [REG_W-1:0]  out_rb,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_we,
  output logic              out_jump,
  output logic              out_cjump,
  output logic              out_beq,
  output logic              out_bne,
  output logic              out_bge,
  output logic              out_blt,
  output logic              out_jalr,
  output logic              out_ill,
  output logic              trap,
  input  logic              trap_clr
);

  localparam int IMM_W = INST_W - 4 - 3 * REG_W;

  typedef struct packed {
    logic [2:0]       op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [XLEN-1:0]  imm;
    logic             we;
    logic             jump;
    logic             cjump;
    logic             beq;
    logic             bne;
    logic             bge;
    logic             blt;
    logic             jalr;
    logic             ill;
  } dec_t;

  logic [3:0]       opcode;
  logic [IMM_W-1:0] imm_raw;
  logic [XLEN-1:0]  imm_ext;
  dec_t             dec;
  dec_t             out_q;
  dec_t             skid_q;
  logic             skid_valid;
  logic             in_xfer;
  logic             out_free;

  assign opcode  = in_inst[3:0];
  assign imm_raw = in_inst[INST_W-1 -: IMM_W];

  if (SEXT_IMM != 0) begin : g_sext
    assign imm_ext = XLEN'($signed(imm_raw));
  end else begin : g_zext
    assign imm_ext = XLEN'(imm_raw);
  end

  // NOTE: default every field first so no path through the case leaves a latch.
  always_comb begin
    dec     = '0;
    dec.op  = opcode[2:0];
    dec.rd  = in_inst[4 +: REG_W];
    dec.ra  = in_inst[4 + REG_W +: REG_W];
    dec.rb  = in_inst[4 + 2 * REG_W +: REG_W];
    dec.imm = imm_ext;
    case (opcode)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: dec.we = 1'b1;
      4'd5:  begin dec.jump = 1'b1; dec.cjump = 1'b1; dec.beq = 1'b1; end
      4'd6:  begin dec.jump = 1'b1; dec.cjump = 1'b1; dec.bne = 1'b1; end
      4'd7:  begin dec.jump = 1'b1; dec.cjump = 1'b1; dec.bge = 1'b1; end
      4'd9:  begin dec.jump = 1'b1; dec.cjump = 1'b1; dec.blt = 1'b1; end
      4'd11: begin dec.jump = 1'b1; dec.we = 1'b1; end
      4'd12: begin dec.jump = 1'b1; dec.we = 1'b1; dec.jalr = 1'b1; end
      default: dec.ill = 1'b1;
    endcase
  end

  assign in_ready = !skid_valid && !flush && !trap;
  assign in_xfer  = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // The data registers are reset too: outputs must read 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      // in_ready is low while the skid holds data, so only one source can load.
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

`ifdef DECODE_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap <= 1'b0;
    end else if (flush) begin
      trap <= 1'b0;
    end else if (in_xfer && dec.ill) begin
      trap <= 1'b1;
    end else if (trap_clr) begin
      trap <= 1'b0;
    end
  end
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr;
  assign trap            = 1'b0;
`endif

  assign out_op    = out_q.op;
  assign out_rd    = out_q.rd;
  assign out_ra    = out_q.ra;
  assign out_rb    = out_q.rb;
  assign out_imm   = out_q.imm;
  assign out_we    = out_q.we;
  assign out_jump  = out_q.jump;
  assign out_cjump = out_q.cjump;
  assign out_beq   = out_q.beq;
  assign out_bne   = out_q.bne;
  assign out_bge   = out_q.bge;
  assign out_blt   = out_q.blt;
  assign out_jalr  = out_q.jalr;
  assign out_ill   = out_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage (default parameters): the driver queues the
// hand-computed decode of each accepted word; a monitor checks every output beat.
module tb_decode_stage;

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] imm;
    logic [8:0]  fl;
  } exp_t;

  // flag order: we jump cjump beq bne bge blt jalr ill
  localparam logic [8:0] WE = 9'h100, JMP = 9'h080, CJ = 9'h040, BEQ = 9'h020,
                         BNE = 9'h010, BGE = 9'h008, BLT = 9'h004, JALR = 9'h002,
                         ILL = 9'h001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_op;
  logic [3:0]  out_rd, out_ra, out_rb;
  logic [31:0] out_imm;
  logic        out_we, out_jump, out_cjump, out_beq, out_bne, out_bge, out_blt;
  logic        out_jalr, out_ill, trap;
  logic        trap_clr = 1'b0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_ra(out_ra), .out_rb(out_rb),
    .out_imm(out_imm), .out_we(out_we), .out_jump(out_jump), .out_cjump(out_cjump),
    .out_beq(out_beq), .out_bne(out_bne), .out_bge(out_bge), .out_blt(out_blt),
    .out_jalr(out_jalr), .out_ill(out_ill), .trap(trap), .trap_clr(trap_clr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t act;

  assign act = {out_op, out_rd, out_ra, out_rb, out_imm, out_we, out_jump, out_cjump,
                out_beq, out_bne, out_bge, out_blt, out_jalr, out_ill};

  function automatic exp_t mk(logic [2:0] op, logic [3:0] rd, logic [3:0] ra,
                              logic [3:0] rb, logic [31:0] imm, logic [8:0] fl);
    return exp_t'({op, rd, ra, rb, imm, fl});
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] inst, input exp_t e);
    in_valid = 1'b1;
    in_inst  = inst;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    tests++;
    fails++;
    $display("FAIL send_timeout: inst %h never accepted", inst);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    step();
  endtask

  // Monitor: every output beat must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %h expected no output", act);
        end else begin
          e = sb.pop_front();
          check("decode_out", 64'(act), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;

    // Reset state
    #2;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_trap", 64'(trap), 64'd0);
    check("reset_fields", 64'(act), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'd1);
    step();

    // Latency: valid on the cycle right after acceptance
    out_ready = 1'b1;
    send(32'h0005_1231, mk(3'd1, 4'd3, 4'd2, 4'd1, 32'h0000_0005, WE));
    @(negedge clk);
    check("latency_valid", 64'(out_valid), 64'd1);
    step();
    drain();

    // Full throughput, one instruction per cycle
    t0 = cyc;
    send(32'hFFFF_0005, mk(3'd5, 4'd0, 4'd0, 4'd0, 32'hFFFF_FFFF, JMP | CJ | BEQ));
    send(32'h8000_A986, mk(3'd6, 4'd8, 4'd9, 4'hA, 32'hFFFF_8000, JMP | CJ | BNE));
    send(32'h7FFF_0007, mk(3'd7, 4'd0, 4'd0, 4'd0, 32'h0000_7FFF, JMP | CJ | BGE));
    send(32'h0001_0009, mk(3'd1, 4'd0, 4'd0, 4'd0, 32'h0000_0001, JMP | CJ | BLT));
    send(32'h0002_345B, mk(3'd3, 4'd5, 4'd4, 4'd3, 32'h0000_0002, JMP | WE));
    send(32'h0000_0C0C, mk(3'd4, 4'd0, 4'hC, 4'd0, 32'h0000_0000, JMP | WE | JALR));
    send(32'h0000_0004, mk(3'd4, 4'd0, 4'd0, 4'd0, 32'h0000_0000, WE));
    check("throughput_cycles", 64'(cyc - t0), 64'd7);
    drain();

    // Stall: two accepted, third blocked, then A B C back-to-back
    out_ready = 1'b0;
    send(32'h0005_1231, mk(3'd1, 4'd3, 4'd2, 4'd1, 32'h0000_0005, WE));
    send(32'h0002_345B, mk(3'd3, 4'd5, 4'd4, 4'd3, 32'h0000_0002, JMP | WE));
    in_valid = 1'b1;
    in_inst  = 32'h7FFF_0007;
    @(negedge clk);
    check("stall_ready_low", 64'(in_ready), 64'd0);
    check("stall_hold_a", 64'(act), 64'(mk(3'd1, 4'd3, 4'd2, 4'd1, 32'h5, WE)));
    step();
    @(negedge clk);
    check("stall_ready_low2", 64'(in_ready), 64'd0);
    check("stall_hold_a2", 64'(act), 64'(mk(3'd1, 4'd3, 4'd2, 4'd1, 32'h5, WE)));
    step();
    out_ready = 1'b1;
    fork
      send(32'h7FFF_0007, mk(3'd7, 4'd0, 4'd0, 4'd0, 32'h0000_7FFF, JMP | CJ | BGE));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("stall_release_nogap", 64'(out_valid), 64'd1);
      end
    join
    drain();

    // Illegal opcodes and trap behaviour
`ifdef DECODE_TRAP_EN
    send(32'h0000_000D, mk(3'd5, 4'd0, 4'd0, 4'd0, 32'h0, ILL));
    @(negedge clk);
    check("trap_set", 64'(trap), 64'd1);
    check("trap_ill_out", 64'(out_ill), 64'd1);
    step();
    in_valid = 1'b1;
    in_inst  = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("trap_blocks_input", 64'(in_ready), 64'd0);
      step();
    end
    trap_clr = 1'b1;
    step();
    trap_clr = 1'b0;
    check("trap_cleared", 64'(trap), 64'd0);
    send(32'h0000_0001, mk(3'd1, 4'd0, 4'd0, 4'd0, 32'h0, WE));
    drain();
    send(32'h0000_000F, mk(3'd7, 4'd0, 4'd0, 4'd0, 32'h0, ILL));
    @(negedge clk);
    check("trap_set2", 64'(trap), 64'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_clears_trap", 64'(trap), 64'd0);
    drain();
`else
    t0 = cyc;
    send(32'h0000_000D, mk(3'd5, 4'd0, 4'd0, 4'd0, 32'h0, ILL));
    send(32'h0000_0001, mk(3'd1, 4'd0, 4'd0, 4'd0, 32'h0, WE));
    check("ill_no_block", 64'(cyc - t0), 64'd2);
    check("trap_tied_low", 64'(trap), 64'd0);
    send(32'h1234_FFFE, mk(3'd6, 4'hF, 4'hF, 4'hF, 32'h0000_1234, ILL));
    send(32'h0000_0008, mk(3'd0, 4'd0, 4'd0, 4'd0, 32'h0, ILL));
    send(32'h0000_000A, mk(3'd2, 4'd0, 4'd0, 4'd0, 32'h0, ILL));
    send(32'h0000_000F, mk(3'd7, 4'd0, 4'd0, 4'd0, 32'h0, ILL));
    drain();
`endif

    // Flush with both entries full, then flush with an input presented
    out_ready = 1'b0;
    send(32'h0005_1231, mk(3'd1, 4'd3, 4'd2, 4'd1, 32'h0000_0005, WE));
    send(32'h0002_345B, mk(3'd3, 4'd5, 4'd4, 4'd3, 32'h0000_0002, JMP | WE));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h0000_0004;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_ready_back", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_nothing_emitted", 64'(out_valid), 64'd0);
    end
    step();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h0000_0004;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_input_dropped", 64'(out_valid), 64'd0);
    step();

    // Reset mid-stream with both entries full
    out_ready = 1'b0;
    send(32'h0005_1231, mk(3'd1, 4'd3, 4'd2, 4'd1, 32'h0000_0005, WE));
    send(32'h0002_345B, mk(3'd3, 4'd5, 4'd4, 4'd3, 32'h0000_0002, JMP | WE));
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_fields", 64'(act), 64'd0);
    check("midreset_trap", 64'(trap), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_ready", 64'(in_ready), 64'd1);
    check("midreset_empty", 64'(out_valid), 64'd0);
    step();
    out_ready = 1'b1;
    send(32'h0000_0C0C, mk(3'd4, 4'd0, 4'hC, 4'd0, 32'h0000_0000, JMP | WE | JALR));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
